// File: rtl/alu_seq_pkg.sv
// Package alu_seq_pkg
//  Shared definitions for the ALU command sequencer and its combinational ALU:
//  opcode encodings, FSM state encoding, response flag bit positions and the
//  latched-command record.
//  Optional feature macro used by the top: ALU_SEQ_PERF_EN (performance counter).
package alu_seq_pkg;

    localparam int RF_DEPTH  = 4;
    localparam int REG_IDX_W = 2;
    localparam int OPC_W     = 4;
    localparam int FLAGS_W   = 4;
    localparam int PERF_W    = 16;

    localparam logic [OPC_W-1:0] OP_LOAD = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADC  = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OPC_W-1:0] OP_INC  = 4'd4;
    localparam logic [OPC_W-1:0] OP_DEC  = 4'd5;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd6;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OPC_W-1:0] OP_ROL  = 4'd8;
    localparam logic [OPC_W-1:0] OP_ROR  = 4'd9;

    // Bit positions inside rsp_flags = {parity, zero, borrow, carry}
    localparam int FLG_C = 0;
    localparam int FLG_B = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_P = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    // Register indices and opcode captured at the accept edge
    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } seq_cmd_t;

    // Opcodes 10..15 are reserved and rejected with rsp_err
    function automatic logic op_is_valid(input logic [OPC_W-1:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu.sv
// Module alu
//  Combinational datapath ALU driven by the sequencer.
//  Ports:
//   a, b       in   BUS_WIDTH  operands (b unused by unary ops)
//   carry_in   in   1          carry for ADC
//   opcode     in   4          OP_ADD..OP_ROR; anything else yields y=0
//   y          out  BUS_WIDTH  result, modulo 2^BUS_WIDTH
//   carry_out  out  1          carry out of ADC / INC (0 for every other op)
//   borrow     out  1          borrow out of SUB / DEC (0 for every other op)
//   zero       out  1          y == 0
//   parity     out  1          XOR of all bits of y
module alu
    import alu_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic [OPC_W-1:0]     opcode,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity
);

    always_comb begin
        y         = '0;
        carry_out = 1'b0;
        borrow    = 1'b0;
        case (opcode)
            // Plain modular add; the carry-reporting add is ADC
            OP_ADD: y = a + b;
            OP_ADC: {carry_out, y} = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
            OP_SUB: begin
                y      = a - b;
                borrow = (a < b);
            end
            OP_INC: {carry_out, y} = {1'b0, a} + {{BUS_WIDTH{1'b0}}, 1'b1};
            OP_DEC: begin
                y      = a - {{(BUS_WIDTH-1){1'b0}}, 1'b1};
                borrow = (a == '0);
            end
            OP_AND: y = a & b;
            OP_NOT: y = ~a;
            OP_ROL: y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
            OP_ROR: y = {a[0], a[BUS_WIDTH-1:1]};
            default: y = '0;
        endcase
    end

    assign zero   = (y == '0);
    assign parity = ^y;

endmodule

// File: rtl/alu_seq_regfile.sv
// Module alu_seq_regfile
//  NUM_REGS x BUS_WIDTH register file, two combinational read ports and one
//  synchronous write port; contents clear on asynchronous reset.
//  Ports:
//   clk, rst_n             clock, async active-low reset
//   rd_addr_a / rd_data_a  read port A
//   rd_addr_b / rd_data_b  read port B
//   wr_en, wr_addr, wr_data  write port (captured on the rising edge)
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_REGS  = RF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rd_addr_a,
    output logic [BUS_WIDTH-1:0] rd_data_a,
    input  logic [REG_IDX_W-1:0] rd_addr_b,
    output logic [BUS_WIDTH-1:0] rd_data_b,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0] wr_data
);

    logic [NUM_REGS-1:0][BUS_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0][BUS_WIDTH-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write value, so rd may alias rs1/rs2
    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Module alu_op_sequencer
//  Command-driven controller around the combinational ALU. One command is
//  accepted per handshake, operands are read from a 4-entry register file,
//  the result is written back, the sticky carry/borrow flag is updated and a
//  response is returned. Sequence: IDLE (accept) -> EXEC (compute/write) ->
//  RESP (hold until consumed).
//  Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm   command fields
//   rsp_valid / rsp_ready       response handshake
//   rsp_result, rsp_flags, rsp_err   response payload ({P,Z,B,C} flags)
//   flag_c                      sticky carry/borrow, feeds ALU carry_in
//   perf_cnt                    successful-command counter (ALU_SEQ_PERF_EN only)
//  Optional feature macro: ALU_SEQ_PERF_EN
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_REGS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OPC_W-1:0]     cmd_opcode,
    input  logic [REG_IDX_W-1:0] cmd_rd,
    input  logic [REG_IDX_W-1:0] cmd_rs1,
    input  logic [REG_IDX_W-1:0] cmd_rs2,
    input  logic [BUS_WIDTH-1:0] cmd_imm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BUS_WIDTH-1:0] rsp_result,
    output logic [FLAGS_W-1:0]   rsp_flags,
    output logic                 rsp_err,
    output logic                 flag_c
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_cnt
`endif
);

    seq_state_e           state_q, state_d;
    seq_cmd_t             cmd_q, cmd_d;
    logic [BUS_WIDTH-1:0] imm_q, imm_d;
    logic [BUS_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [FLAGS_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 flag_c_q, flag_c_d;

    logic [BUS_WIDTH-1:0] rf_a, rf_b;
    logic                 rf_wr_en;
    logic [BUS_WIDTH-1:0] rf_wr_data;

    logic [BUS_WIDTH-1:0] alu_y;
    logic                 alu_carry, alu_borrow, alu_zero, alu_parity;

    alu_seq_regfile #(
        .BUS_WIDTH (BUS_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (cmd_q.rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (cmd_q.rs2),
        .rd_data_b (rf_b),
        .wr_en     (rf_wr_en),
        .wr_addr   (cmd_q.rd),
        .wr_data   (rf_wr_data)
    );

    alu #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_alu (
        .a         (rf_a),
        .b         (rf_b),
        .carry_in  (flag_c_q),
        .opcode    (cmd_q.opcode),
        .y         (alu_y),
        .carry_out (alu_carry),
        .borrow    (alu_borrow),
        .zero      (alu_zero),
        .parity    (alu_parity)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            imm_q        <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            flag_c_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            imm_q        <= imm_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            flag_c_q     <= flag_c_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        imm_d        = imm_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        flag_c_d     = flag_c_q;
        rf_wr_en     = 1'b0;
        rf_wr_data   = alu_y;
        cmd_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_d.opcode = cmd_opcode;
                    cmd_d.rd     = cmd_rd;
                    cmd_d.rs1    = cmd_rs1;
                    cmd_d.rs2    = cmd_rs2;
                    imm_d        = cmd_imm;
                    state_d      = EXEC;
                end
            end

            EXEC: begin
                state_d     = RESP;
                rsp_err_d   = 1'b0;
                rsp_flags_d = '0;
                if (!op_is_valid(cmd_q.opcode)) begin
                    rsp_err_d    = 1'b1;
                    rsp_result_d = '0;
                end else if (cmd_q.opcode == OP_LOAD) begin
                    rf_wr_en            = 1'b1;
                    rf_wr_data          = imm_q;
                    rsp_result_d        = imm_q;
                    rsp_flags_d[FLG_P]  = ^imm_q;
                    rsp_flags_d[FLG_Z]  = (imm_q == '0);
                end else begin
                    rf_wr_en            = 1'b1;
                    rsp_result_d        = alu_y;
                    rsp_flags_d[FLG_P]  = alu_parity;
                    rsp_flags_d[FLG_Z]  = alu_zero;
                    rsp_flags_d[FLG_B]  = alu_borrow;
                    rsp_flags_d[FLG_C]  = alu_carry;
                    case (cmd_q.opcode)
                        OP_ADC, OP_INC: flag_c_d = alu_carry;
                        OP_SUB, OP_DEC: flag_c_d = alu_borrow;
                        default:        flag_c_d = 1'b0;
                    endcase
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign flag_c     = flag_c_q;

`ifdef ALU_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_cnt_q, perf_cnt_d;

    // Counts consumed error-free responses, saturating at all-ones
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (rsp_valid && rsp_ready && !rsp_err_q && (perf_cnt_q != {PERF_W{1'b1}})) begin
            perf_cnt_d = perf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule
